// File: rtl/tetris_key_pkg.sv
// rtl/tetris_key_pkg.sv - scan codes, state types and key decode for tetris_key_cmd
// Purpose: shared constants for the Tetris keyboard command block.
//   SC_*         set-2 scan codes (E0 prefix already stripped)
//   K_*          bit index of each game key in held/pulse vectors
//   rpt_state_t  auto-repeat timer state
//   dir_t        horizontal direction
//   key_onehot() maps a scan code to a one-hot game-key vector (0 if unmapped)
package tetris_key_pkg;

  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_ROTATE = 8'h75;
  localparam logic [7:0] SC_DROP   = 8'h29;
  localparam logic [7:0] SC_PAUSE  = 8'h76;

  localparam int NUM_KEYS = 6;
  localparam int K_LEFT   = 0;
  localparam int K_RIGHT  = 1;
  localparam int K_DOWN   = 2;
  localparam int K_ROTATE = 3;
  localparam int K_DROP   = 4;
  localparam int K_PAUSE  = 5;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  typedef enum logic {DIR_L, DIR_R} dir_t;

  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code);
    logic [NUM_KEYS-1:0] oh;
    oh = '0;
    case (code)
      SC_LEFT:   oh[K_LEFT]   = 1'b1;
      SC_RIGHT:  oh[K_RIGHT]  = 1'b1;
      SC_DOWN:   oh[K_DOWN]   = 1'b1;
      SC_ROTATE: oh[K_ROTATE] = 1'b1;
      SC_DROP:   oh[K_DROP]   = 1'b1;
      SC_PAUSE:  oh[K_PAUSE]  = 1'b1;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// rtl/key_repeat_timer.sv - delayed auto-repeat tick generator
// Purpose: after start, ticks once FIRST cycles later and then every PERIOD
// cycles until stop.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   start   (re)arm: counter to 0, enter DELAY; wins over stop
//   stop    disarm: back to IDLE
//   tick    combinational repeat request; suppressed when start/stop is high
module key_repeat_timer
  import tetris_key_pkg::*;
#(
  parameter int FIRST  = 12,
  parameter int PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start,
  input  logic stop,
  output logic tick
);

  localparam int MAXV = (FIRST > PERIOD) ? FIRST : PERIOD;
  localparam int W    = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam logic [W-1:0] FIRST_M1  = W'(FIRST - 1);
  localparam logic [W-1:0] PERIOD_M1 = W'(PERIOD - 1);

  rpt_state_t     state_q;
  logic [W-1:0]   cnt_q;
  logic           match;

  always_comb begin
    match = 1'b0;
    case (state_q)
      DELAY:   match = (cnt_q == FIRST_M1);
      REPEAT:  match = (cnt_q == PERIOD_M1);
      default: match = 1'b0;
    endcase
  end

  // A same-cycle start or stop replaces the pending tick, so a press never
  // produces two pulses and a release never lets a late repeat escape.
  assign tick = match & ~start & ~stop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (start) begin
      state_q <= DELAY;
      cnt_q   <= '0;
    end else if (stop) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (match) begin
      state_q <= REPEAT;
      cnt_q   <= '0;
    end else if (state_q != IDLE) begin
      cnt_q   <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/tetris_key_cmd.sv
// rtl/tetris_key_cmd.sv - PS/2 key events to single-cycle Tetris commands
// Purpose: tracks held game keys, drops typematic repeats and generates
// delayed auto-shift for left/right and a fixed repeat for soft drop.
// Ports:
//   CLOCK_74   clock
//   reset      asynchronous active-low reset
//   valid      makeBreak/outCode meaningful this cycle
//   makeBreak  1 = press, 0 = release
//   outCode    set-2 scan code
//   cmd_*      registered one-cycle command pulses
module tetris_key_cmd
  import tetris_key_pkg::*;
#(
  parameter int DAS_DELAY   = 12_622_500,
  parameter int ARR_PERIOD  = 3_712_500,
  parameter int DOWN_PERIOD = 3_712_500
) (
  input  logic       CLOCK_74,
  input  logic       reset,
  input  logic       valid,
  input  logic       makeBreak,
  input  logic [7:0] outCode,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_down,
  output logic       cmd_rotate,
  output logic       cmd_drop,
  output logic       cmd_pause
);

  logic                valid_q;
  logic [8:0]          last_word_q;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] cmd_q, cmd_d;
  dir_t                dir_q, dir_d;

  logic [8:0]          word;
  logic                accept;
  logic [NUM_KEYS-1:0] hit, press, rel;
  logic                h_start, h_stop, h_tick, d_tick;

  // A held-high valid with an unchanged word is a single event.
  always_comb begin
    word   = {makeBreak, outCode};
    accept = valid & (~valid_q | (word != last_word_q));
    hit    = key_onehot(outCode);
    press  = (accept & makeBreak)  ? (hit & ~held_q) : '0;
    rel    = (accept & ~makeBreak) ? (hit & held_q)  : '0;
    held_d = (held_q | press) & ~rel;
  end

  // Last-pressed direction wins; releasing it hands over to the other
  // direction if still held, restarting the DAS delay without a pulse.
  always_comb begin
    dir_d   = dir_q;
    h_start = 1'b0;
    h_stop  = 1'b0;
    if (press[K_LEFT]) begin
      dir_d   = DIR_L;
      h_start = 1'b1;
    end else if (press[K_RIGHT]) begin
      dir_d   = DIR_R;
      h_start = 1'b1;
    end else if (rel[K_LEFT] && (dir_q == DIR_L)) begin
      if (held_q[K_RIGHT]) begin
        dir_d   = DIR_R;
        h_start = 1'b1;
      end else begin
        h_stop  = 1'b1;
      end
    end else if (rel[K_RIGHT] && (dir_q == DIR_R)) begin
      if (held_q[K_LEFT]) begin
        dir_d   = DIR_L;
        h_start = 1'b1;
      end else begin
        h_stop  = 1'b1;
      end
    end
  end

  always_comb begin
    cmd_d           = '0;
    cmd_d[K_LEFT]   = press[K_LEFT]  | (h_tick & (dir_q == DIR_L));
    cmd_d[K_RIGHT]  = press[K_RIGHT] | (h_tick & (dir_q == DIR_R));
    cmd_d[K_DOWN]   = press[K_DOWN]  | d_tick;
    cmd_d[K_ROTATE] = press[K_ROTATE];
    cmd_d[K_DROP]   = press[K_DROP];
    cmd_d[K_PAUSE]  = press[K_PAUSE];
  end

  key_repeat_timer #(.FIRST(DAS_DELAY), .PERIOD(ARR_PERIOD)) u_h_timer (
    .clk_i  (CLOCK_74),
    .rst_ni (reset),
    .start  (h_start),
    .stop   (h_stop),
    .tick   (h_tick)
  );

  key_repeat_timer #(.FIRST(DOWN_PERIOD), .PERIOD(DOWN_PERIOD)) u_d_timer (
    .clk_i  (CLOCK_74),
    .rst_ni (reset),
    .start  (press[K_DOWN]),
    .stop   (rel[K_DOWN]),
    .tick   (d_tick)
  );

  always_ff @(posedge CLOCK_74 or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      last_word_q <= '0;
      held_q      <= '0;
      dir_q       <= DIR_L;
      cmd_q       <= '0;
    end else begin
      valid_q     <= valid;
      if (accept) last_word_q <= word;
      held_q      <= held_d;
      dir_q       <= dir_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd_left   = cmd_q[K_LEFT];
  assign cmd_right  = cmd_q[K_RIGHT];
  assign cmd_down   = cmd_q[K_DOWN];
  assign cmd_rotate = cmd_q[K_ROTATE];
  assign cmd_drop   = cmd_q[K_DROP];
  assign cmd_pause  = cmd_q[K_PAUSE];

endmodule

// File: tb/tb_tetris_key_cmd.sv
// tb/tb_tetris_key_cmd.sv - scoreboard bench for tetris_key_cmd
module tb_tetris_key_cmd;

  localparam int DAS = 10;
  localparam int ARR = 4;
  localparam int DWN = 3;

  logic       CLOCK_74 = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic       makeBreak = 1'b0;
  logic [7:0] outCode = 8'h00;
  logic       cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop, cmd_pause;

  tetris_key_cmd #(.DAS_DELAY(DAS), .ARR_PERIOD(ARR), .DOWN_PERIOD(DWN)) dut (
    .CLOCK_74   (CLOCK_74),
    .reset      (reset),
    .valid      (valid),
    .makeBreak  (makeBreak),
    .outCode    (outCode),
    .cmd_left   (cmd_left),
    .cmd_right  (cmd_right),
    .cmd_down   (cmd_down),
    .cmd_rotate (cmd_rotate),
    .cmd_drop   (cmd_drop),
    .cmd_pause  (cmd_pause)
  );

  always #5 CLOCK_74 = ~CLOCK_74;

  typedef struct {
    int         t;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   edge_n = 0;
  int   pulse_cnt = 0;

  // Reference model: schedule of absolute edge numbers for the next repeat.
  bit         held[6];
  int         m_dir = 0;
  int         h_next = -1;
  int         d_next = -1;
  bit         m_prev_valid = 1'b0;
  logic [8:0] m_last_word = '0;

  function automatic logic [5:0] dut_vec();
    return {cmd_pause, cmd_drop, cmd_rotate, cmd_down, cmd_right, cmd_left};
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
  endtask

  // Bit order: left, right, down, rotate, drop, pause.
  function automatic int key_idx(input logic [7:0] c);
    case (c)
      8'h6B:   return 0;
      8'h74:   return 1;
      8'h72:   return 2;
      8'h75:   return 3;
      8'h29:   return 4;
      8'h76:   return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    logic [8:0] w;
    bit         acc, hrep, drep;
    int         idx;
    logic [5:0] v;
    edge_n++;
    if (!reset) begin
      for (int i = 0; i < 6; i++) held[i] = 1'b0;
      m_dir = 0; h_next = -1; d_next = -1;
      m_prev_valid = 1'b0; m_last_word = '0;
      return;
    end
    w   = {makeBreak, outCode};
    acc = valid && (!m_prev_valid || (w != m_last_word));
    m_prev_valid = valid;
    if (acc) m_last_word = w;
    v    = '0;
    hrep = (h_next == edge_n);
    drep = (d_next == edge_n);
    idx  = acc ? key_idx(outCode) : -1;
    if (idx >= 0) begin
      if (makeBreak && !held[idx]) begin
        held[idx] = 1'b1;
        v[idx]    = 1'b1;
        if (idx <= 1) begin
          m_dir = idx; h_next = edge_n + DAS; hrep = 1'b0;
        end else if (idx == 2) begin
          d_next = edge_n + DWN; drep = 1'b0;
        end
      end else if (!makeBreak && held[idx]) begin
        held[idx] = 1'b0;
        if (idx <= 1 && idx == m_dir) begin
          hrep = 1'b0;
          if (held[1-idx]) begin
            m_dir = 1 - idx; h_next = edge_n + DAS;
          end else begin
            h_next = -1;
          end
        end
        if (idx == 2) begin
          drep = 1'b0; d_next = -1;
        end
      end
    end
    if (hrep) begin v[m_dir] = 1'b1; h_next = edge_n + ARR; end
    if (drep) begin v[2] = 1'b1; d_next = edge_n + DWN; end
    if (v != 0) q.push_back('{edge_n, v});
  endtask

  initial forever begin
    @(posedge CLOCK_74);
    model_step();
  end

  // Monitor: compares whenever the DUT pulses or a pulse is due.
  initial forever begin
    logic [5:0] dv;
    exp_t       e;
    @(negedge CLOCK_74);
    dv = dut_vec();
    if (dv != 0) begin
      pulse_cnt++;
      chk(!(cmd_left && cmd_right), "left_right_exclusive", int'(cmd_left & cmd_right), 0);
    end
    if (dv != 0 || (q.size() > 0 && q[0].t == edge_n)) begin
      if (q.size() == 0 || q[0].t != edge_n) begin
        chk(1'b0, "unexpected_pulse", int'(dv), 0);
      end else begin
        e = q.pop_front();
        chk(dv == e.v, "pulse_vector", int'(dv), int'(e.v));
      end
    end
    while (q.size() > 0 && q[0].t < edge_n) begin
      e = q.pop_front();
      chk(1'b0, "missing_pulse", 0, int'(e.v));
    end
  end

  task automatic ev(input logic mb, input logic [7:0] code);
    @(negedge CLOCK_74);
    valid = 1'b1; makeBreak = mb; outCode = code;
    @(negedge CLOCK_74);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge CLOCK_74);
  endtask

  logic [7:0] codes [7];
  int         pc0;

  initial begin
    codes = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'h76, 8'h1C};

    repeat (3) @(negedge CLOCK_74);
    chk(dut_vec() == 0, "reset_state", int'(dut_vec()), 0);
    reset = 1'b1;
    idle(2);

    // Hold left 30 cycles.
    ev(1'b1, 8'h6B); repeat (29) @(negedge CLOCK_74); ev(1'b0, 8'h6B); idle(15);

    // Typematic make on rotate.
    ev(1'b1, 8'h75); idle(4); ev(1'b1, 8'h75); idle(2); ev(1'b0, 8'h75); idle(5);

    // Direction override and hand-back.
    ev(1'b1, 8'h6B); idle(4); ev(1'b1, 8'h74); idle(14);
    ev(1'b0, 8'h74); idle(20); ev(1'b0, 8'h6B); idle(8);

    // Held valid on drop, then unmapped code.
    @(negedge CLOCK_74); valid = 1'b1; makeBreak = 1'b1; outCode = 8'h29;
    repeat (6) @(negedge CLOCK_74);
    valid = 1'b0;
    ev(1'b0, 8'h29); ev(1'b1, 8'h1C); ev(1'b0, 8'h1C); idle(5);

    // Down repeat.
    ev(1'b1, 8'h72); repeat (7) @(negedge CLOCK_74); ev(1'b0, 8'h72); idle(10);

    // Back-to-back events.
    @(negedge CLOCK_74); valid = 1'b1; makeBreak = 1'b1; outCode = 8'h75;
    @(negedge CLOCK_74); outCode = 8'h76;
    @(negedge CLOCK_74); makeBreak = 1'b0; outCode = 8'h75;
    @(negedge CLOCK_74); outCode = 8'h76;
    @(negedge CLOCK_74); valid = 1'b0;
    idle(4);

    // Reset while left is repeating, timed onto a live pulse.
    ev(1'b1, 8'h6B); repeat (18) @(negedge CLOCK_74);
    #1 reset = 1'b0;
    #1 chk(dut_vec() == 0, "reset_clears_outputs", int'(dut_vec()), 0);
    repeat (3) @(negedge CLOCK_74);
    reset = 1'b1;
    pc0 = pulse_cnt;
    idle(20);
    chk(pulse_cnt == pc0, "quiet_after_reset", pulse_cnt - pc0, 0);
    ev(1'b1, 8'h6B); idle(12); ev(1'b0, 8'h6B); idle(5);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      int ci;
      @(negedge CLOCK_74);
      if ($urandom_range(0, 14) == 0) begin
        valid = 1'b0;
        repeat ($urandom_range(5, 25)) @(negedge CLOCK_74);
      end
      ci        = int'($urandom_range(0, 6));
      valid     = ($urandom_range(0, 3) == 0);
      makeBreak = ($urandom_range(0, 2) != 0);
      outCode   = codes[ci];
    end
    idle(30);
    chk(q.size() == 0, "scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
